// File: rtl/acc_shift_pkg.sv
// Shared definitions for the shifting product accumulator: mode encodings and a
// constant-safe ceiling-log2 used to size the term counter.
package acc_shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_ADD  = 2'b10,
    MODE_SHR  = 2'b11
  } mode_e;

  // Bits needed to encode values 0..value-1; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/acc_shift_reg_operand_shifter.sv
// Combinational operand aligner: zero-extends datain, shifts it left by whole
// SHIFT_UNIT steps, truncates to WIDTH and flags any discarded one bits.
module operand_shifter #(
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned SHIFT_W    = 2,
  parameter int unsigned SHIFT_UNIT = 4,
  parameter int unsigned WIDTH      = 16
) (
  input  logic [IN_WIDTH-1:0] datain,
  input  logic [SHIFT_W-1:0]  shift_sel,
  output logic [WIDTH-1:0]    opnd,
  output logic                lost
);

  localparam int unsigned EXT_W  = IN_WIDTH + ((1 << SHIFT_W) - 1) * SHIFT_UNIT;
  // Never narrower than WIDTH so the truncation slice below is always legal.
  localparam int unsigned FULL_W = (EXT_W > WIDTH) ? EXT_W : WIDTH;

  logic [FULL_W-1:0] shifted;

  always_comb begin
    shifted = FULL_W'(datain) << (32'(shift_sel) * SHIFT_UNIT);
  end

  assign opnd = shifted[WIDTH-1:0];

  if (FULL_W > WIDTH) begin : g_lost
    assign lost = |shifted[FULL_W-1:WIDTH];
  end else begin : g_no_lost
    assign lost = 1'b0;
  end

endmodule

// File: rtl/acc_shift_reg.sv
// Accumulating register with hold/load/add/shift-right modes, sticky overflow,
// a saturating term counter and a one-cycle done pulse on reaching ACC_COUNT.
module acc_shift_reg
  import acc_shift_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned SHIFT_W    = 2,
  parameter int unsigned SHIFT_UNIT = 4,
  parameter int unsigned ACC_COUNT  = 4
) (
  input  logic                              clk,
  input  logic                              aclr_n,
  input  logic                              sclr_n,
  input  logic                              clk_ena,
  input  logic [1:0]                        mode,
  input  logic [IN_WIDTH-1:0]               datain,
  input  logic [SHIFT_W-1:0]                shift_sel,
  output logic [WIDTH-1:0]                  reg_out,
  output logic                              ovf,
  output logic [clog2(ACC_COUNT+1)-1:0]     acc_cnt,
  output logic                              done
);

  localparam int unsigned CNT_W = clog2(ACC_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACC_COUNT);

  if (ACC_COUNT < 1 || WIDTH < IN_WIDTH || SHIFT_UNIT < 1) begin : g_param_check
    $error("acc_shift_reg: illegal parameter combination");
  end

  logic [WIDTH-1:0] opnd;
  logic             lost;
  logic [WIDTH:0]   sum;

  logic [WIDTH-1:0] reg_d, reg_q;
  logic             ovf_d, ovf_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             done_d, done_q;

  operand_shifter #(
    .IN_WIDTH  (IN_WIDTH),
    .SHIFT_W   (SHIFT_W),
    .SHIFT_UNIT(SHIFT_UNIT),
    .WIDTH     (WIDTH)
  ) u_operand_shifter (
    .datain   (datain),
    .shift_sel(shift_sel),
    .opnd     (opnd),
    .lost     (lost)
  );

  assign sum = {1'b0, reg_q} + {1'b0, opnd};

  always_comb begin
    reg_d  = reg_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (!sclr_n) begin
      reg_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (clk_ena) begin
      case (mode_e'(mode))
        MODE_LOAD: begin
          reg_d  = opnd;
          ovf_d  = lost;
          cnt_d  = CNT_W'(1);
          done_d = (ACC_COUNT == 1);
        end
        MODE_ADD: begin
          reg_d = sum[WIDTH-1:0];
          ovf_d = ovf_q | lost | sum[WIDTH];
          // Saturated counter suppresses further done pulses.
          if (cnt_q < CNT_MAX) begin
            cnt_d  = cnt_q + CNT_W'(1);
            done_d = (cnt_q + CNT_W'(1) == CNT_MAX);
          end
        end
        MODE_SHR: reg_d = reg_q >> SHIFT_UNIT;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      reg_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      reg_q  <= reg_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign reg_out = reg_q;
  assign ovf     = ovf_q;
  assign acc_cnt = cnt_q;
  assign done    = done_q;

endmodule

// File: tb/tb_acc_shift_reg.sv
// Directed bench for acc_shift_reg: reset behaviour, a 4-term 8x8 product,
// enable gating, overflow, truncation, shift-right and counter saturation.
module tb_acc_shift_reg;

  logic        clk;
  logic        aclr_n;
  logic        sclr_n;
  logic        clk_ena;
  logic [1:0]  mode;
  logic [7:0]  datain;
  logic [1:0]  shift_sel;
  logic [15:0] reg_out;
  logic        ovf;
  logic [2:0]  acc_cnt;
  logic        done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] ADD  = 2'b10;
  localparam logic [1:0] SHR  = 2'b11;

  acc_shift_reg #(
    .WIDTH     (16),
    .IN_WIDTH  (8),
    .SHIFT_W   (2),
    .SHIFT_UNIT(4),
    .ACC_COUNT (4)
  ) dut (
    .clk      (clk),
    .aclr_n   (aclr_n),
    .sclr_n   (sclr_n),
    .clk_ena  (clk_ena),
    .mode     (mode),
    .datain   (datain),
    .shift_sel(shift_sel),
    .reg_out  (reg_out),
    .ovf      (ovf),
    .acc_cnt  (acc_cnt),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] r, input logic o,
                         input logic [2:0] c, input logic d);
    chk({tag, ".reg_out"}, 32'(reg_out), 32'(r));
    chk({tag, ".ovf"},     32'(ovf),     32'(o));
    chk({tag, ".acc_cnt"}, 32'(acc_cnt), 32'(c));
    chk({tag, ".done"},    32'(done),    32'(d));
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic [1:0] m, input logic [7:0] d, input logic [1:0] s);
    mode      = m;
    datain    = d;
    shift_sel = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    aclr_n    = 1'b0;
    sclr_n    = 1'b1;
    clk_ena   = 1'b0;
    mode      = HOLD;
    datain    = '0;
    shift_sel = '0;
    #1;
    chk_all("reset_initial", 16'h0000, 1'b0, 3'd0, 1'b0);

    @(posedge clk);
    #1;
    aclr_n  = 1'b1;
    clk_ena = 1'b1;

    // Build 0x1234 then assert async reset mid-cycle.
    step(LOAD, 8'h34, 2'd0);
    chk_all("load_34", 16'h0034, 1'b0, 3'd1, 1'b0);
    step(ADD, 8'h12, 2'd2);
    chk_all("build_1234", 16'h1234, 1'b0, 3'd2, 1'b0);
    #2;
    aclr_n = 1'b0;
    #1;
    chk_all("async_clear", 16'h0000, 1'b0, 3'd0, 1'b0);
    aclr_n = 1'b1;

    // Synchronous clear wins over a disabled LOAD.
    step(LOAD, 8'h34, 2'd0);
    chk_all("reload_34", 16'h0034, 1'b0, 3'd1, 1'b0);
    sclr_n  = 1'b0;
    clk_ena = 1'b0;
    step(LOAD, 8'hFF, 2'd0);
    chk_all("sync_clear", 16'h0000, 1'b0, 3'd0, 1'b0);
    sclr_n  = 1'b1;
    clk_ena = 1'b1;

    // 0xAB * 0xCD from nibble partial products, with an enable gap.
    step(LOAD, 8'd143, 2'd0);
    chk_all("prod_t1", 16'd143, 1'b0, 3'd1, 1'b0);
    step(ADD, 8'd130, 2'd1);
    chk_all("prod_t2", 16'd2223, 1'b0, 3'd2, 1'b0);
    clk_ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(ADD, 8'hFF, 2'd0);
      chk_all("ena_gap", 16'd2223, 1'b0, 3'd2, 1'b0);
    end
    clk_ena = 1'b1;
    step(ADD, 8'd132, 2'd1);
    chk_all("prod_t3", 16'd4335, 1'b0, 3'd3, 1'b0);
    step(ADD, 8'd120, 2'd2);
    chk_all("prod_t4", 16'h88EF, 1'b0, 3'd4, 1'b1);
    step(HOLD, 8'hFF, 2'd3);
    chk_all("prod_hold", 16'h88EF, 1'b0, 3'd4, 1'b0);

    // Shift right then saturated ADD: no second done pulse.
    step(SHR, 8'h00, 2'd0);
    chk_all("shr", 16'h088E, 1'b0, 3'd4, 1'b0);
    step(ADD, 8'h01, 2'd0);
    chk_all("sat_add", 16'h088F, 1'b0, 3'd4, 1'b0);

    // Overflow is sticky until the next LOAD.
    step(LOAD, 8'hFF, 2'd2);
    chk_all("ovf_load", 16'hFF00, 1'b0, 3'd1, 1'b0);
    step(ADD, 8'hFF, 2'd2);
    chk_all("ovf_add", 16'hFE00, 1'b1, 3'd2, 1'b0);
    step(HOLD, 8'h00, 2'd0);
    chk_all("ovf_hold", 16'hFE00, 1'b1, 3'd2, 1'b0);
    step(LOAD, 8'h01, 2'd0);
    chk_all("ovf_reload", 16'h0001, 1'b0, 3'd1, 1'b0);

    // Operand shifted entirely out of range.
    step(LOAD, 8'hF0, 2'd3);
    chk_all("trunc_load", 16'h0000, 1'b1, 3'd1, 1'b0);
    step(LOAD, 8'h0F, 2'd3);
    chk_all("top_nibble_load", 16'hF000, 1'b0, 3'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
